// File: rtl/ex_pkg.sv
// ============================================================================
// ex_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the execute-stage result buffer:
//   - default ALU result width and register-file address width
//   - bit positions inside the 3-bit ALU flag vector {Overflow, CarryOut, Zero}
//   - occupancy-state encoding of the 2-entry result buffer.  The encoding
//     equals the number of stored entries, so the state register doubles as
//     the occupancy count.
// ============================================================================
package ex_pkg;

    localparam int EX_DATA_WIDTH = 32;
    localparam int EX_RF_ADDR_W  = 5;

    localparam int FLAG_OVF = 2;
    localparam int FLAG_CF  = 1;
    localparam int FLAG_ZF  = 0;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // True when an ALU result must raise an overflow exception: the op is a
    // checked signed add/sub and the ALU reported overflow.
    function automatic logic ovfTrap(input logic ovfChk, input logic [2:0] flags);
        return ovfChk & flags[FLAG_OVF];
    endfunction

endpackage

// File: rtl/ex_result_buffer.sv
// ============================================================================
// ex_result_buffer
// ----------------------------------------------------------------------------
// Two-entry FIFO that decouples the ALU from the next pipeline stage.  Each
// entry holds the ALU result, its flags, the destination register, the write
// enable and an overflow-exception bit.
//
// Optional feature (compile-time macro OVERFLOW_TRAP_EN):
//   defined   : exc = in_ovf_chk & Overflow is stored with each entry and the
//               register write is suppressed for an excepting entry.
//   undefined : out_exc is always 0, in_wen is stored unchanged and
//               in_ovf_chk is ignored.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   asynchronous, active-low reset
//   in_valid   in   upstream presents a result
//   in_ready   out  buffer can accept an entry this cycle
//   in_result  in   ALU result               [DATA_WIDTH]
//   in_flags   in   {Overflow, CarryOut, Zero}
//   in_ovf_chk in   signed add/sub whose overflow is checked
//   in_wdest   in   destination register      [RF_ADDR_W]
//   in_wen     in   register write enable
//   flush      in   synchronous discard of all entries (highest priority)
//   out_valid  out  head entry is valid
//   out_ready  in   downstream consumes the head
//   out_result/out_flags/out_wdest/out_wen/out_exc  out  head entry, 0 when empty
//   count      out  occupancy 0..2
// ============================================================================
module ex_result_buffer
    import ex_pkg::*;
#(
    parameter int DATA_WIDTH = EX_DATA_WIDTH,
    parameter int RF_ADDR_W  = EX_RF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic [2:0]            in_flags,
    input  logic                  in_ovf_chk,
    input  logic [RF_ADDR_W-1:0]  in_wdest,
    input  logic                  in_wen,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [2:0]            out_flags,
    output logic [RF_ADDR_W-1:0]  out_wdest,
    output logic                  out_wen,
    output logic                  out_exc,
    output logic [1:0]            count
);

    logic [1:0] state_q, state_d;
    logic       wrPtr_q, wrPtr_d;
    logic       rdPtr_q, rdPtr_d;

    // Cleared by reset and set on the first rising edge afterwards, so that
    // in_ready stays low for the whole reset period even though the
    // occupancy state reads EMPTY.
    logic       live_q;

    logic [DATA_WIDTH-1:0] result_q [2];
    logic [2:0]            flags_q  [2];
    logic [RF_ADDR_W-1:0]  wdest_q  [2];
    logic                  wen_q    [2];
    logic                  exc_q    [2];

    logic push;
    logic pop;
    logic excIn;
    logic wenIn;

    assign in_ready  = live_q && (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign count     = state_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

`ifdef OVERFLOW_TRAP_EN
    assign excIn = ovfTrap(in_ovf_chk, in_flags);
    assign wenIn = in_wen & ~excIn;
`else
    logic unusedOvfChk;
    assign unusedOvfChk = in_ovf_chk;
    assign excIn        = 1'b0;
    assign wenIn        = in_wen;
`endif

    // Occupancy and pointer next-state.  Flush overrides any same-cycle push
    // or pop.  A FULL buffer never pushes because in_ready is low there.
    always_comb begin
        state_d = state_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (flush) begin
            state_d = ST_EMPTY;
            wrPtr_d = 1'b0;
            rdPtr_d = 1'b0;
        end else begin
            if (push) begin
                wrPtr_d = ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_d = ~rdPtr_q;
            end
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && !pop) begin
                        state_d = ST_FULL;
                    end else if (pop && !push) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            live_q  <= 1'b1;
        end
    end

    // Entry storage.  Only the slot under the write pointer is written; a
    // flushed push must not leave data behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                result_q[i] <= '0;
                flags_q[i]  <= '0;
                wdest_q[i]  <= '0;
                wen_q[i]    <= 1'b0;
                exc_q[i]    <= 1'b0;
            end
        end else if (push && !flush) begin
            result_q[wrPtr_q] <= in_result;
            flags_q[wrPtr_q]  <= in_flags;
            wdest_q[wrPtr_q]  <= in_wdest;
            wen_q[wrPtr_q]    <= wenIn;
            exc_q[wrPtr_q]    <= excIn;
        end
    end

    // Head entry is forced to zero while the buffer is empty so stale data
    // never reaches the writeback stage.
    always_comb begin
        out_result = '0;
        out_flags  = '0;
        out_wdest  = '0;
        out_wen    = 1'b0;
        out_exc    = 1'b0;
        if (out_valid) begin
            out_result = result_q[rdPtr_q];
            out_flags  = flags_q[rdPtr_q];
            out_wdest  = wdest_q[rdPtr_q];
            out_wen    = wen_q[rdPtr_q];
            out_exc    = exc_q[rdPtr_q];
        end
    end

endmodule

// File: tb/tb_ex_result_buffer.sv
module tb_ex_result_buffer;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_result = '0;
    logic [2:0]    in_flags = '0;
    logic          in_ovf_chk = 1'b0;
    logic [AW-1:0] in_wdest = '0;
    logic          in_wen = 1'b0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_result;
    logic [2:0]    out_flags;
    logic [AW-1:0] out_wdest;
    logic          out_wen;
    logic          out_exc;
    logic [1:0]    count;

    always #5 clk = ~clk;

    ex_result_buffer #(.DATA_WIDTH(DW), .RF_ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_flags   (in_flags),
        .in_ovf_chk (in_ovf_chk),
        .in_wdest   (in_wdest),
        .in_wen     (in_wen),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_wdest  (out_wdest),
        .out_wen    (out_wen),
        .out_exc    (out_exc),
        .count      (count)
    );

    typedef struct {
        logic [DW-1:0] result;
        logic [2:0]    flags;
        logic [AW-1:0] wdest;
        logic          wen;
        logic          exc;
    } entry_t;

    // Reference model: an ordered list of stored entries plus a flag telling
    // whether a clock edge has been seen since reset was released.
    entry_t model[$];
    bit     armed = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic entry_t makeEntry(input logic [DW-1:0] res, input logic [2:0] fl,
                                         input logic ovf, input logic [AW-1:0] wd, input logic we);
        entry_t e;
        e.result = res;
        e.flags  = fl;
        e.wdest  = wd;
`ifdef OVERFLOW_TRAP_EN
        e.exc = ovf && fl[2];
        e.wen = we && !e.exc;
`else
        e.exc = 1'b0;
        e.wen = we;
`endif
        return e;
    endfunction

    task automatic checkModel();
        entry_t head;
        head = '{default: '0};
        if (model.size() > 0) begin
            head = model[0];
        end
        checkOutput("count",      64'(count),      64'(model.size()));
        checkOutput("out_valid",  64'(out_valid),  64'(model.size() > 0));
        checkOutput("in_ready",   64'(in_ready),   64'(armed && model.size() < 2));
        checkOutput("out_result", 64'(out_result), 64'(head.result));
        checkOutput("out_flags",  64'(out_flags),  64'(head.flags));
        checkOutput("out_wdest",  64'(out_wdest),  64'(head.wdest));
        checkOutput("out_wen",    64'(out_wen),    64'(head.wen));
        checkOutput("out_exc",    64'(out_exc),    64'(head.exc));
    endtask

    // One clock cycle: drive inputs, check outputs against the model on the
    // falling edge, then advance the model by what the rising edge must do.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] res, input logic [2:0] fl,
                                 input logic ovf, input logic [AW-1:0] wd, input logic we,
                                 input logic fsh, input logic ordy);
        entry_t e;
        bit     doPush;
        bit     doPop;
        in_valid   = v;
        in_result  = res;
        in_flags   = fl;
        in_ovf_chk = ovf;
        in_wdest   = wd;
        in_wen     = we;
        flush      = fsh;
        out_ready  = ordy;
        @(negedge clk);
        checkModel();
        doPush = v && armed && (model.size() < 2);
        doPop  = (model.size() > 0) && ordy;
        e = makeEntry(res, fl, ovf, wd, we);
        @(posedge clk);
        #1;
        armed = 1'b1;
        if (fsh) begin
            model.delete();
        end else begin
            if (doPop) begin
                model.delete(0);
            end
            if (doPush) begin
                model.push_back(e);
            end
        end
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, '0, 3'b000, 1'b0, '0, 1'b0, 1'b0, ordy);
    endtask

    task automatic push(input logic [DW-1:0] res, input logic [AW-1:0] wd, input logic ordy);
        applyStimulus(1'b1, res, 3'b000, 1'b0, wd, 1'b1, 1'b0, ordy);
    endtask

    // Assert reset between clock edges, hold it, and release it; in_ready
    // must stay low until the first rising edge after release.
    task automatic doReset(input int holdCycles);
        #2 rst = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #1;
        model.delete();
        armed = 1'b0;
        checkOutput("rst_count",     64'(count),      64'd0);
        checkOutput("rst_out_valid", 64'(out_valid),  64'd0);
        checkOutput("rst_in_ready",  64'(in_ready),   64'd0);
        checkOutput("rst_result",    64'(out_result), 64'd0);
        repeat (holdCycles) @(posedge clk);
        #1;
        checkOutput("rst_held_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rel_ready_pre_edge", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        armed = 1'b1;
        checkOutput("rel_ready_post_edge", 64'(in_ready), 64'd1);
        checkOutput("rel_count",           64'(count),    64'd0);
        checkOutput("rel_out_valid",       64'(out_valid), 64'd0);
    endtask

    initial begin
        doReset(3);

        // Single push with immediate consumption.
        applyStimulus(1'b1, 32'h0000_0005, 3'b000, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        checkOutput("after_single_empty", 64'(count), 64'd0);
        idle(1'b1);

        // Fill while stalled, attempt a third push, then drain in order.
        push(32'hA, 5'd1, 1'b0);
        push(32'hB, 5'd2, 1'b0);
        push(32'hC, 5'd4, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Push and pop in the same cycle while holding one entry.
        push(32'h1, 5'd5, 1'b0);
        push(32'h2, 5'd6, 1'b1);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Flush in FULL with a push and pop pending.
        push(32'h11, 5'd7, 1'b0);
        push(32'h22, 5'd8, 1'b0);
        applyStimulus(1'b1, 32'h33, 3'b001, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Checked signed overflow.
        applyStimulus(1'b1, 32'h8000_0000, 3'b100, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
`ifdef OVERFLOW_TRAP_EN
        checkOutput("ovf_exc", 64'(out_exc), 64'd1);
        checkOutput("ovf_wen", 64'(out_wen), 64'd0);
`else
        checkOutput("ovf_exc", 64'(out_exc), 64'd0);
        checkOutput("ovf_wen", 64'(out_wen), 64'd1);
`endif
        idle(1'b1);
        idle(1'b1);

        // Reset while holding entries.
        push(32'h77, 5'd11, 1'b0);
        push(32'h88, 5'd12, 1'b0);
        doReset(2);
        idle(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 99) < 60),
                          32'($urandom),
                          3'($urandom),
                          1'($urandom),
                          5'($urandom),
                          1'($urandom),
                          1'($urandom_range(0, 99) < 4),
                          1'($urandom_range(0, 99) < 50));
        end

        doReset(1);
        idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
